// File: rtl/rrp_burst_arbiter_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  localparam int unsigned DEF_MAX_BURST = 16;

  // Bits needed to index v items; never less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rrp_burst_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or
// above 'start', wrapping around to channel 0.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan all channels once starting from 'start'; first hit wins.
  always_comb begin
    int unsigned c;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      c = (int'(start) + k) % N;
      if (!valid && req[c]) begin
        valid    = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/rrp_burst_arbiter.sv
// Round-robin burst arbiter merging N FWFT source FIFOs into one stream.
// Optional per-channel word counters are built when ARB_CNT_EN is defined.
module rrp_burst_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N_CH      = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST,
  parameter int unsigned CNT_W     = 32,
  localparam int unsigned OW       = clog2(N_CH)
) (
  input  logic                     BUS_CLK,
  input  logic                     BUS_RST,
  input  logic [N_CH-1:0]          WRITE_REQ,
  input  logic [N_CH-1:0]          HOLD_REQ,
  input  logic [N_CH-1:0]          CH_ENABLE,
  input  logic [N_CH*DATA_W-1:0]   DATA_IN,
  output logic [N_CH-1:0]          READ_GRANT,
  input  logic                     READY_OUT,
  output logic                     WRITE_OUT,
  output logic [DATA_W-1:0]        DATA_OUT,
  output logic [OW-1:0]            OWNER
`ifdef ARB_CNT_EN
  ,
  output logic [N_CH*CNT_W-1:0]    WORD_CNT,
  input  logic                     CNT_CLR
`endif
);

  localparam int unsigned BW = clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAXC = BW'(MAX_BURST);

  if (N_CH < 2 || N_CH > 16 || MAX_BURST < 1 || MAX_BURST > 256 || CNT_W < 1)
  begin : g_bad_params
    $error("rrp_burst_arbiter: parameter out of range");
  end

  state_t            state, state_n;
  logic [OW-1:0]     owner_n, ptr, owner_inc, owner_n_inc;
  logic [BW-1:0]     cnt, cnt_n;
  logic [N_CH-1:0]   req, own_oh, others, grant;
  logic [N_CH-1:0]   pk_req, pk_grant;
  logic [OW-1:0]     pk_start, pk_idx;
  logic              pk_valid;
  logic [DATA_W-1:0] pop_data;

  assign req        = WRITE_REQ & CH_ENABLE;
  assign others     = req & ~own_oh;
  assign READ_GRANT = grant;

  // Decode owner and its round-robin successors.
  always_comb begin
    own_oh        = '0;
    own_oh[OWNER] = 1'b1;
    owner_inc     = (OWNER == OW'(N_CH - 1)) ? '0 : OWNER + OW'(1);
    owner_n_inc   = (owner_n == OW'(N_CH - 1)) ? '0 : owner_n + OW'(1);
  end

  // One encoder serves both the idle pick and re-arbitration; in a burst
  // the current owner is masked out, which also covers the "only
  // requester" case because that case is caught by the continue rule.
  assign pk_req   = (state == IDLE) ? req : others;
  assign pk_start = (state == IDLE) ? ptr : owner_inc;

  rr_pick #(
    .N  (N_CH),
    .IW (OW)
  ) u_pick (
    .req   (pk_req),
    .start (pk_start),
    .grant (pk_grant),
    .idx   (pk_idx),
    .valid (pk_valid)
  );

  // Next-state, burst counter and pop decision.
  always_comb begin
    state_n = state;
    owner_n = OWNER;
    cnt_n   = cnt;
    grant   = '0;
    if (!BUS_RST) begin
      unique case (state)
        IDLE: begin
          if (pk_valid && READY_OUT) begin
            grant   = pk_grant;
            owner_n = pk_idx;
            cnt_n   = BW'(1);
            state_n = BURST;
          end
        end
        BURST: begin
          if (!READY_OUT) begin
            state_n = BURST;
          end else if (req[OWNER] && (HOLD_REQ[OWNER] || cnt < MAXC || others == '0)) begin
            grant = own_oh;
            if (HOLD_REQ[OWNER] || cnt < MAXC)
              cnt_n = (cnt == MAXC) ? cnt : cnt + BW'(1);
            else
              cnt_n = BW'(1);
          end else if (!req[OWNER] && HOLD_REQ[OWNER] && CH_ENABLE[OWNER]) begin
            state_n = BURST;
          end else if (pk_valid) begin
            grant   = pk_grant;
            owner_n = pk_idx;
            cnt_n   = BW'(1);
          end else begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Select the word being popped this cycle.
  always_comb begin
    pop_data = '0;
    for (int unsigned i = 0; i < N_CH; i++)
      if (grant[i]) pop_data = DATA_IN[i*DATA_W +: DATA_W];
  end

  // State, owner, pointer and registered output stream.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state     <= IDLE;
      OWNER     <= '0;
      cnt       <= '0;
      ptr       <= '0;
      WRITE_OUT <= 1'b0;
      DATA_OUT  <= '0;
    end else begin
      state     <= state_n;
      OWNER     <= owner_n;
      cnt       <= cnt_n;
      WRITE_OUT <= |grant;
      if (|grant) begin
        DATA_OUT <= pop_data;
        ptr      <= owner_n_inc;
      end
    end
  end

`ifdef ARB_CNT_EN
  logic [CNT_W-1:0] wcnt [N_CH];

  // Saturating per-channel pop counters; clear wins over a coincident grant.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST || CNT_CLR) begin
      for (int unsigned i = 0; i < N_CH; i++) wcnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++)
        if (grant[i] && wcnt[i] != '1) wcnt[i] <= wcnt[i] + CNT_W'(1);
    end
  end

  // Flatten counters onto the status port.
  always_comb begin
    WORD_CNT = '0;
    for (int unsigned i = 0; i < N_CH; i++) WORD_CNT[i*CNT_W +: CNT_W] = wcnt[i];
  end
`endif

endmodule

// File: doc/rrp_burst_arbiter.md
Name: rrp_burst_arbiter

Overview:
- Parametrised successor to the fixed 7-input readout arbiter.
- Merges N first-word-fall-through source FIFOs (RX, direct RX, TLU, timestamp channels) into one 32-bit stream toward the SiTCP/USB FIFO.
- Adds over the previous arbiter:
  - configurable channel count and data width;
  - bounded burst length per grant;
  - atomic HOLD frames;
  - runtime per-channel enable mask;
  - zero dead cycles between grants.
- Sits in the core between the per-module FIFO outputs and ARB_DATA_OUT/ARB_WRITE_OUT.

Parameters:
- N_CH, 8, number of source channels (2..16).
- DATA_W, 32, word width.
- MAX_BURST, 16, maximum consecutive words per grant when no HOLD (1..256).
- CNT_W, 32, width of optional per-channel word counters.

Ports:
- BUS_CLK  in  1  single clock for the whole block.
- BUS_RST  in  1  synchronous, active-high reset.
- WRITE_REQ  in  N_CH  source FIFO not-empty; DATA_IN slice is valid while high.
- HOLD_REQ  in  N_CH  keeps the grant on channel i across gaps, so multi-word frames stay atomic.
- CH_ENABLE  in  N_CH  request mask; 0 = channel ignored.
- DATA_IN  in  N_CH*DATA_W  concatenated source data; channel i occupies [i*DATA_W +: DATA_W].
- READ_GRANT  out  N_CH  one-hot pop strobe, combinational.
- READY_OUT  in  1  downstream can accept a word.
- WRITE_OUT  out  1  registered write strobe.
- DATA_OUT  out  DATA_W  registered data.
- OWNER  out  clog2(N_CH)  index of the current or last grantee, for debug/status.
- WORD_CNT  out  N_CH*CNT_W  only with ARB_CNT_EN.
- CNT_CLR  in  1  only with ARB_CNT_EN.

Behaviour:
- Reset values (BUS_RST sampled high at a BUS_CLK edge):
  - WRITE_OUT=0, DATA_OUT=0, READ_GRANT=0, OWNER=0;
  - state=IDLE, burst counter=0, round-robin pointer=0.
  - Reset mid-burst aborts the burst; the word popped in the reset cycle is not emitted.
- Effective request: req[i] = WRITE_REQ[i] & CH_ENABLE[i].
- Round-robin pick: first req[i] found searching upward from (OWNER+1) mod N_CH, wrapping. After reset the search starts at channel 0.
- State IDLE:
  - If any req and READY_OUT: pop the picked channel this cycle (READ_GRANT one-hot), OWNER<=pick, cnt<=1, go to BURST.
  - Otherwise READ_GRANT=0.
- State BURST, evaluated in priority order:
  1. READY_OUT=0: no pop, state held.
  2. req[OWNER] and (HOLD_REQ[OWNER] or cnt<MAX_BURST or no other req): pop OWNER, cnt<=cnt+1.
     - cnt saturates; it resets to 1 when the burst continues solely because no other channel is requesting.
  3. !req[OWNER] and HOLD_REQ[OWNER] and CH_ENABLE[OWNER]: stall with grant retained (atomic frame gap), no pop.
  4. Else re-arbitrate in the same cycle, excluding OWNER unless it is the only requester. If a pick exists: pop it, OWNER<=pick, cnt<=1. If none: go to IDLE.
- Output timing:
  - WRITE_OUT/DATA_OUT register the popped word; latency is exactly 1 cycle from READ_GRANT to WRITE_OUT.
  - Downstream must absorb one word after deasserting READY_OUT.
- Disable during a frame: clearing CH_ENABLE[OWNER] mid-HOLD releases the grant immediately, with no further pops from that channel.
- Invariants:
  - READ_GRANT is never asserted for a channel with WRITE_REQ=0.
  - At most one bit of READ_GRANT is set.
- MAX_BURST=1 gives pure word-interleaved round robin (HOLD still overrides).

Optional Feature:
- Macro: ARB_CNT_EN.
- Defined:
  - WORD_CNT[i] increments on each READ_GRANT[i] and saturates at all-ones.
  - CNT_CLR (synchronous) zeroes all counters; if a grant coincides with the clear, the counter becomes 0, not 1.
  - BUS_RST zeroes all counters.
- Undefined: WORD_CNT and CNT_CLR ports are absent and there is no counter logic.

Decomposition:
- Package arb_pkg holds the state enum {IDLE, BURST}, the clog2 helper, and the default MAX_BURST constant.
- One sub-module, rr_pick: combinational round-robin priority encoder (req vector, start index → one-hot, index, valid). It is reused for the initial pick and for re-arbitration.

Test Plan:
- N_CH=4, MAX_BURST=4, all channels have 10 words queued, READY_OUT=1 → emission order ch0×4, ch1×4, ch2×4, ch3×4, ch0×4…, no idle cycles; WRITE_OUT follows READ_GRANT by 1 cycle.
- ch1 HOLD_REQ=1 with a 6-word frame containing a 3-cycle WRITE_REQ gap, ch2 requesting → all 6 ch1 words are contiguous in the output; READ_GRANT=0 during the gap; ch2 starts right after.
- READY_OUT toggles 1,0,0,1 every cycle while 2 channels request → exactly one trailing WRITE_OUT after each drop; no pops while READY_OUT=0; no words lost or duplicated.
- Only ch3 requesting, 40 words, MAX_BURST=4 → continuous 40-word stream; OWNER stays 3.
- ch0 mid-HOLD, CH_ENABLE[0] cleared → no ch0 pops from the next cycle; ch1 granted in that cycle; BUS_RST asserted mid-burst → all outputs are 0 on the next edge.
- ARB_CNT_EN defined: 5 words from ch2, then CNT_CLR coincident with a grant → WORD_CNT[2] reads 5, then 0.
